// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM state type and byte/word primitives.
// The cipher datapath reuses the S-box and word helpers.
package aes_pkg;

    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_KEY_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } ksState_e;

    // Index 0 is the leftmost byte, so SBOX_TABLE[x] is S(x).
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sBox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rotWord(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sBox(w[31:24]), sBox(w[23:16]), sBox(w[15:8]), sBox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: current round key plus rcon in, next round key out.
module aes_key_round_step
    import aes_pkg::*;
(
    input  logic [127:0] iKey,
    input  logic [7:0]   iRcon,
    output logic [127:0] oKey
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0   = iKey[127:96];
        w1   = iKey[95:64];
        w2   = iKey[63:32];
        w3   = iKey[31:0];
        temp = subWord(rotWord(w3)) ^ {iRcon, 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        oKey = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key schedule: one round key per cycle, streamed out and kept in an
// 11-entry buffer with a registered random-access read port.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR    = AES_NR,
    parameter int unsigned KEY_W = AES_KEY_W
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [KEY_W-1:0] iAesKey,
    output logic             oBusy,
    output logic             oDone,
    output logic             oKeyValid,
    output logic [KEY_W-1:0] oRoundKey,
    output logic [3:0]       oRoundIdx,
    input  logic [3:0]       iRdAddr,
    output logic [KEY_W-1:0] oRdKey,
    output logic             oRdValid
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ksState_e         state;
    logic [KEY_W-1:0] workKey;
    logic [KEY_W-1:0] nextKey;
    logic [3:0]       roundCnt;
    logic [7:0]       rcon;
    logic [NR:0]      validBits;
    logic [KEY_W-1:0] keyBuf [0:NR];
    logic             rdHit;
    logic [KEY_W-1:0] rdData;

    aes_key_round_step uRoundStep (
        .iKey  (workKey),
        .iRcon (rcon),
        .oKey  (nextKey)
    );

    assign oBusy = (state == LOAD) || (state == EXPAND);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            workKey   <= '0;
            roundCnt  <= 4'd0;
            rcon      <= 8'h01;
            validBits <= '0;
            oDone     <= 1'b0;
            oKeyValid <= 1'b0;
            oRoundKey <= '0;
            oRoundIdx <= 4'd0;
        end else begin
            oDone     <= 1'b0;
            oKeyValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        workKey   <= iAesKey;
                        validBits <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    validBits[0] <= 1'b1;
                    oKeyValid    <= 1'b1;
                    oRoundIdx    <= 4'd0;
                    oRoundKey    <= workKey;
                    roundCnt     <= 4'd1;
                    rcon         <= 8'h01;
                    state        <= EXPAND;
                end
                EXPAND: begin
                    workKey             <= nextKey;
                    validBits[roundCnt] <= 1'b1;
                    oKeyValid           <= 1'b1;
                    oRoundIdx           <= roundCnt;
                    oRoundKey           <= nextKey;
                    // Counter and rcon park on the last round; LOAD re-seeds both.
                    if (roundCnt == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        roundCnt <= roundCnt + 4'd1;
                        rcon     <= xtime(rcon);
                    end
                end
                DONE: begin
                    oDone <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer data is not reset; the valid bits alone gate what the read port exposes.
    always_ff @(posedge iClk) begin
        if (state == LOAD) begin
            keyBuf[0] <= workKey;
        end else if (state == EXPAND) begin
            keyBuf[roundCnt] <= nextKey;
        end
    end

    always_comb begin
        rdHit  = 1'b0;
        rdData = '0;
        if (iRdAddr <= LAST_IDX && validBits[iRdAddr]) begin
            rdHit  = 1'b1;
            rdData = keyBuf[iRdAddr];
        end
    end

    // Non-blocking read of the array gives pre-write data on a same-cycle collision.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRdKey   <= '0;
            oRdValid <= 1'b0;
        end else begin
            oRdKey   <= rdData;
            oRdValid <= rdHit;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a word-level key-expansion model whose
// S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_schedule;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic [127:0] iAesKey;
    logic         oBusy;
    logic         oDone;
    logic         oKeyValid;
    logic [127:0] oRoundKey;
    logic [3:0]   oRoundIdx;
    logic [3:0]   iRdAddr;
    logic [127:0] oRdKey;
    logic         oRdValid;

    int unsigned passCnt  = 0;
    int unsigned totalCnt = 0;

    logic [7:0]   refSbox [256];
    logic [127:0] refKeys [11];
    logic [127:0] got     [11];

    localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1    = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_schedule dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iAesKey   (iAesKey),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oKeyValid (oKeyValid),
        .oRoundKey (oRoundKey),
        .oRoundIdx (oRoundIdx),
        .iRdAddr   (iRdAddr),
        .oRdKey    (oRdKey),
        .oRdValid  (oRdValid)
    );

    always #5 iClk = ~iClk;

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            refSbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                         ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subRot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {refSbox[r[31:24]], refSbox[r[23:16]], refSbox[r[15:8]], refSbox[r[7:0]]};
    endfunction

    task automatic buildRef(input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            if (i % 4 == 0) begin
                w[i] = w[i-4] ^ subRot(w[i-1]) ^ {rc, 24'h000000};
                rc   = gfMul(rc, 8'h02);
            end else begin
                w[i] = w[i-4] ^ w[i-1];
            end
        end
        for (int r = 0; r < 11; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalCnt++;
        assert (obs === exp) begin
            passCnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    // rdMode 0: random address, 1: entry being written at that edge, 2: two ahead of it.
    function automatic logic [3:0] pickAddr(input int rdMode, input int k);
        if (rdMode == 1) return 4'(k - 1);
        if (rdMode == 2) return 4'(k + 1);
        return 4'($urandom_range(0, 15));
    endfunction

    // Starts a run and checks every edge from acceptance (k=0) to the oDone pulse (k=12).
    task automatic runKey(input logic [127:0] key, input bit hold, input int rdMode,
                          input string name);
        logic [3:0] addr;
        bit         expV;
        buildRef(key);
        iAesKey = key;
        iStart  = 1'b1;
        step();
        chk($sformatf("%s/busyT0", name), 128'(oBusy), 128'(1));
        if (hold) iAesKey = key ^ {64'hffff_ffff_ffff_ffff, 64'h0};
        else      iStart  = 1'b0;
        addr    = pickAddr(rdMode, 1);
        iRdAddr = addr;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("%s/kv%0d", name, k), 128'(oKeyValid), 128'(k <= 11));
            chk($sformatf("%s/busy%0d", name, k), 128'(oBusy), 128'(k <= 10));
            chk($sformatf("%s/done%0d", name, k), 128'(oDone), 128'(k == 12));
            if (k <= 11) begin
                chk($sformatf("%s/idx%0d", name, k), 128'(oRoundIdx), 128'(k - 1));
                chk($sformatf("%s/key%0d", name, k), oRoundKey, refKeys[k-1]);
                got[k-1] = oRoundKey;
            end else begin
                chk($sformatf("%s/idxHold", name), 128'(oRoundIdx), 128'(10));
                chk($sformatf("%s/keyHold", name), oRoundKey, refKeys[10]);
            end
            // Entry a is written at edge a+1, so a read resolving at edge k sees it only if a+1<k.
            expV = (int'(addr) <= 10) && (int'(addr) + 1 < k);
            chk($sformatf("%s/rdv%0d_a%0d", name, k, addr), 128'(oRdValid), 128'(expV));
            chk($sformatf("%s/rdk%0d_a%0d", name, k, addr), oRdKey,
                expV ? refKeys[addr] : 128'h0);
            addr    = pickAddr(rdMode, k + 1);
            iRdAddr = addr;
        end
    endtask

    task automatic chkAllZero(input string name);
        chk({name, "/busy"}, 128'(oBusy), 128'(0));
        chk({name, "/done"}, 128'(oDone), 128'(0));
        chk({name, "/kv"}, 128'(oKeyValid), 128'(0));
        chk({name, "/key"}, oRoundKey, 128'h0);
        chk({name, "/idx"}, 128'(oRoundIdx), 128'(0));
        chk({name, "/rdk"}, oRdKey, 128'h0);
        chk({name, "/rdv"}, 128'(oRdValid), 128'(0));
    endtask

    initial begin
        logic [127:0] rndKey;
        logic [127:0] rndKey2;
        buildSbox();
        iRst    = 1'b1;
        iStart  = 1'b0;
        iAesKey = '0;
        iRdAddr = 4'd0;
        repeat (2) @(posedge iClk);
        #1;
        chkAllZero("reset");
        iRst = 1'b0;
        step();

        // FIPS-197 vector with random reads during expansion.
        runKey(FIPS_KEY, 1'b0, 0, "fips");
        chk("fips/k0", got[0], FIPS_KEY);
        chk("fips/k1", got[1], FIPS_K1);
        chk("fips/k10", got[10], FIPS_K10);

        // All-zero key; reads run two entries ahead of the write pointer.
        runKey(128'h0, 1'b0, 2, "zero");
        chk("zero/k1", got[1], ZERO_K1);
        chk("zero/k10", got[10], ZERO_K10);
        for (int a = 10; a >= 0; a--) begin
            iRdAddr = 4'(a);
            step();
            chk($sformatf("readback/v%0d", a), 128'(oRdValid), 128'(1));
            chk($sformatf("readback/k%0d", a), oRdKey, got[a]);
        end
        iRdAddr = 4'd11;
        step();
        chk("guard11/v", 128'(oRdValid), 128'(0));
        chk("guard11/k", oRdKey, 128'h0);
        iRdAddr = 4'd15;
        step();
        chk("guard15/v", 128'(oRdValid), 128'(0));
        chk("guard15/k", oRdKey, 128'h0);

        // iStart held across a run; the follow-on run reads each entry as it is rewritten.
        rndKey  = {$urandom, $urandom, $urandom, $urandom};
        rndKey2 = {$urandom, $urandom, $urandom, $urandom};
        runKey(rndKey, 1'b1, 0, "hold1");
        runKey(rndKey2, 1'b0, 1, "hold2");

        // Asynchronous reset while round key 6 is on the stream.
        buildRef(FIPS_KEY);
        iAesKey = FIPS_KEY;
        iStart  = 1'b1;
        step();
        iStart = 1'b0;
        repeat (7) step();
        chk("mid/idx6", 128'(oRoundIdx), 128'(6));
        chk("mid/key6", oRoundKey, refKeys[6]);
        #2;
        iRst = 1'b1;
        #1;
        chkAllZero("asyncRst");
        step();
        iRst    = 1'b0;
        iRdAddr = 4'd0;
        step();
        chk("postRst/rdv0", 128'(oRdValid), 128'(0));
        chk("postRst/busy", 128'(oBusy), 128'(0));
        runKey(FIPS_KEY, 1'b0, 0, "rerun");
        chk("rerun/k1", got[1], FIPS_K1);
        chk("rerun/k10", got[10], FIPS_K10);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
